// File: rtl/mac_share_arbiter.sv
// ---------------------------------------------------------------------------
// mac_share_arbiter
//   Shares one MAC datapath between two operand requesters. Whole bursts of
//   (a,b) beats are granted round-robin. Accepted beats are registered toward
//   the MAC with accumulator clear/last framing and a per-requester done pulse.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_x/last_x/a_x/b_x  requester x beat valid, end-of-burst flag, operands
//   ack_0, ack_1          beat accepted this cycle (combinational)
//   select                operand mux select (0 = requester 0, 1 = requester 1)
//   mac_a, mac_b          registered operands, held while mac_en = 0
//   mac_en                mac_a/mac_b valid this cycle
//   mac_clear             first beat of a burst (MAC restarts its accumulator)
//   mac_last              final beat of a burst
//   busy                  a burst is granted
//   beat_count            beats accepted in the current or most recent burst
//   done_0, done_1        1-cycle pulse aligned with that requester's last beat
// ---------------------------------------------------------------------------
module mac_share_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_0,
    input  logic             last_0,
    input  logic [WIDTH-1:0] a_0,
    input  logic [WIDTH-1:0] b_0,
    input  logic             req_1,
    input  logic             last_1,
    input  logic [WIDTH-1:0] a_1,
    input  logic [WIDTH-1:0] b_1,
    output logic             ack_0,
    output logic             ack_1,
    output logic             select,
    output logic [WIDTH-1:0] mac_a,
    output logic [WIDTH-1:0] mac_b,
    output logic             mac_en,
    output logic             mac_clear,
    output logic             mac_last,
    output logic             busy,
    output logic [CNT_W-1:0] beat_count,
    output logic             done_0,
    output logic             done_1
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t state;
    logic   owner;   // requester holding (or last holding) the grant
    logic   ptr;     // requester that wins when both ask in IDLE

    logic             req_owner;
    logic             last_owner;
    logic [WIDTH-1:0] a_owner;
    logic [WIDTH-1:0] b_owner;
    logic             accept;
    logic             end_beat;
    logic             winner;

    // NOTE: every signal in an always_comb gets a default before any branch,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        req_owner  = req_0;
        last_owner = last_0;
        a_owner    = a_0;
        b_owner    = b_0;
        if (owner) begin
            req_owner  = req_1;
            last_owner = last_1;
            a_owner    = a_1;
            b_owner    = b_1;
        end

        // Nothing is accepted during reset, so a burst abandoned by reset
        // never shows a handshake on its final cycle.
        accept   = (state == BURST) && req_owner && !reset;
        ack_0    = accept && !owner;
        ack_1    = accept && owner;

        // The beat that brings the count to MAX_BURST is forced last.
        end_beat = accept && (last_owner || (beat_count == CNT_W'(MAX_BURST - 1)));

        // Sole requester wins; on a tie the priority pointer decides.
        winner   = (req_0 && req_1) ? ptr : req_1;
    end

    assign select = owner;
    assign busy   = (state == BURST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // The operand registers are cleared too: every output reads 0
            // after reset.
            state      <= IDLE;
            owner      <= 1'b0;
            ptr        <= 1'b0;
            beat_count <= '0;
            mac_a      <= '0;
            mac_b      <= '0;
            mac_en     <= 1'b0;
            mac_clear  <= 1'b0;
            mac_last   <= 1'b0;
            done_0     <= 1'b0;
            done_1     <= 1'b0;
        end else begin
            // Framing flags are single-cycle; operands hold between beats.
            mac_en    <= 1'b0;
            mac_clear <= 1'b0;
            mac_last  <= 1'b0;
            done_0    <= 1'b0;
            done_1    <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_0 || req_1) begin
                        owner      <= winner;
                        beat_count <= '0;
                        state      <= BURST;
                    end
                end

                BURST: begin
                    if (accept) begin
                        mac_en     <= 1'b1;
                        mac_a      <= a_owner;
                        mac_b      <= b_owner;
                        mac_clear  <= (beat_count == '0);
                        beat_count <= beat_count + 1'b1;
                        if (end_beat) begin
                            mac_last <= 1'b1;
                            done_0   <= !owner;
                            done_1   <= owner;
                            ptr      <= !owner;
                            state    <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mac_share_arbiter
//   Self-checking bench for mac_share_arbiter (MAX_BURST = 4). A burst-level
//   reference model (who holds the grant, beats taken so far, whose turn is
//   next) predicts every output; scenario tasks add directed checks.
// ---------------------------------------------------------------------------
module tb_mac_share_arbiter;

    localparam int W  = 8;
    localparam int MB = 4;
    localparam int CW = $clog2(MB + 1);

    logic          clk;
    logic          reset;
    logic          req_0, last_0, req_1, last_1;
    logic [W-1:0]  a_0, b_0, a_1, b_1;
    logic          ack_0, ack_1, select, mac_en, mac_clear, mac_last, busy;
    logic          done_0, done_1;
    logic [W-1:0]  mac_a, mac_b;
    logic [CW-1:0] beat_count;

    mac_share_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .req_0(req_0), .last_0(last_0), .a_0(a_0), .b_0(b_0),
        .req_1(req_1), .last_1(last_1), .a_1(a_1), .b_1(b_1),
        .ack_0(ack_0), .ack_1(ack_1), .select(select),
        .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en),
        .mac_clear(mac_clear), .mac_last(mac_last), .busy(busy),
        .beat_count(beat_count), .done_0(done_0), .done_1(done_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          en, clear, last, done0, done1, busy, sel;
        logic [CW-1:0] cnt;
        logic [W-1:0]  a, b;
    } out_t;

    typedef struct packed {
        logic         rst, r0, l0;
        logic [W-1:0] a0, b0;
        logic         r1, l1;
        logic [W-1:0] a1, b1;
    } stim_t;

    int checks = 0;
    int errors = 0;

    // Reference model: burst ownership and beat tally.
    bit   m_busy, m_owner, m_ptr;
    int   m_count;
    out_t exp_o;
    logic [1:0] exp_ack, obs_ack;

    function automatic out_t snap();
        out_t s;
        s.en = mac_en; s.clear = mac_clear; s.last = mac_last;
        s.done0 = done_0; s.done1 = done_1; s.busy = busy; s.sel = select;
        s.cnt = beat_count; s.a = mac_a; s.b = mac_b;
        return s;
    endfunction

    function automatic stim_t idle_stim(input logic rst);
        stim_t s;
        s = '0;
        s.rst = rst;
        return s;
    endfunction

    task automatic model_step(input stim_t s);
        bit req_o, last_o;
        exp_o.en = 0; exp_o.clear = 0; exp_o.last = 0;
        exp_o.done0 = 0; exp_o.done1 = 0;
        if (s.rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_count = 0;
            exp_o = '0;
        end else if (!m_busy) begin
            if (s.r0 || s.r1) begin
                m_owner = (s.r0 && s.r1) ? m_ptr : s.r1;
                m_count = 0;
                m_busy  = 1;
            end
        end else begin
            req_o  = m_owner ? s.r1 : s.r0;
            last_o = m_owner ? s.l1 : s.l0;
            if (req_o) begin
                exp_o.en    = 1;
                exp_o.a     = m_owner ? s.a1 : s.a0;
                exp_o.b     = m_owner ? s.b1 : s.b0;
                exp_o.clear = (m_count == 0);
                m_count++;
                if (last_o || m_count == MB) begin
                    exp_o.last = 1;
                    if (m_owner) exp_o.done1 = 1; else exp_o.done0 = 1;
                    m_busy = 0;
                    m_ptr  = !m_owner;
                end
            end
        end
        exp_o.busy = m_busy;
        exp_o.sel  = m_owner;
        exp_o.cnt  = CW'(m_count);
    endtask

    // Drive one cycle's inputs, sample the combinational acks, advance the
    // model, then return at the falling edge with registered outputs settled.
    task automatic drive_cycle(input stim_t s);
        reset = s.rst;
        req_0 = s.r0; last_0 = s.l0; a_0 = s.a0; b_0 = s.b0;
        req_1 = s.r1; last_1 = s.l1; a_1 = s.a1; b_1 = s.b1;
        #1;
        obs_ack = {ack_1, ack_0};
        exp_ack = 2'b00;
        if (!s.rst && m_busy) begin
            if (m_owner) exp_ack[1] = s.r1;
            else         exp_ack[0] = s.r0;
        end
        model_step(s);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            stim_t s = idle_stim(1'b1);
            s.r0 = 1; s.r1 = 1; s.a0 = 8'hAA; s.b0 = 8'h55; s.a1 = 8'h11; s.b1 = 8'h22;
            drive_cycle(s);
            checks++;
            if ({obs_ack, snap()} !== {2'b00, out_t'('0)}) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d: got ack %b out %h, want all zero", i, obs_ack, snap());
            end
        end
    endtask

    task automatic test_single_burst();
        logic [W-1:0] av [3] = '{8'd3, 8'd5, 8'd7};
        logic [W-1:0] bv [3] = '{8'd4, 8'd6, 8'd8};
        int idx = 0, en_n = 0, en_first = -1, en_last = -1, clr_n = 0, done_n = 0;
        drive_cycle(idle_stim(1'b1));
        for (int c = 0; c < 8; c++) begin
            stim_t s = idle_stim(1'b0);
            if (idx < 3) begin
                s.r0 = 1; s.a0 = av[idx]; s.b0 = bv[idx]; s.l0 = (idx == 2);
            end
            drive_cycle(s);
            if (obs_ack[0]) idx++;
            checks++;
            if ({obs_ack, snap()} !== {exp_ack, exp_o}) begin
                errors++;
                $display("FAIL single_model cyc %0d: got %b/%h want %b/%h", c, obs_ack, snap(), exp_ack, exp_o);
            end
            if (mac_en) begin
                en_n++;
                if (en_first < 0) en_first = c;
                en_last = c;
            end
            if (mac_clear) begin
                clr_n++;
                checks++;
                if (mac_a !== 8'd3 || mac_b !== 8'd4) begin
                    errors++;
                    $display("FAIL single_clear_operands: got %0d,%0d want 3,4", mac_a, mac_b);
                end
            end
            if (done_0) begin
                done_n++;
                checks++;
                if ({mac_last, beat_count, select, mac_a, mac_b} !== {1'b1, CW'(3), 1'b0, 8'd7, 8'd8}) begin
                    errors++;
                    $display("FAIL single_done: got last %b cnt %0d sel %b a %0d b %0d want 1 3 0 7 8",
                             mac_last, beat_count, select, mac_a, mac_b);
                end
            end
        end
        checks++;
        if (en_n != 3 || en_last - en_first != 2 || clr_n != 1 || done_n != 1) begin
            errors++;
            $display("FAIL single_framing: got en %0d span %0d clear %0d done %0d want 3 2 1 1",
                     en_n, en_last - en_first, clr_n, done_n);
        end
    endtask

    task automatic test_round_robin();
        bit   idx0 = 0, idx1 = 0;
        int   order [$];
        int   done_cyc [$];
        int   clr_cyc [$];
        out_t pre;
        drive_cycle(idle_stim(1'b1));
        for (int c = 0; c < 20 && order.size() < 3; c++) begin
            stim_t s = idle_stim(1'b0);
            s.r0 = 1; s.l0 = idx0; s.a0 = W'($urandom); s.b0 = W'($urandom);
            s.r1 = 1; s.l1 = idx1; s.a1 = W'($urandom); s.b1 = W'($urandom);
            pre = snap();
            drive_cycle(s);
            if (obs_ack[0]) idx0 = !idx0;
            if (obs_ack[1]) idx1 = !idx1;
            checks++;
            if ({obs_ack, snap()} !== {exp_ack, exp_o}) begin
                errors++;
                $display("FAIL rr_model cyc %0d: got %b/%h want %b/%h", c, obs_ack, snap(), exp_ack, exp_o);
            end
            if (pre.busy && !pre.sel) begin
                checks++;
                if (obs_ack[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_ack1_during_owner0 cyc %0d: got %b want 0", c, obs_ack[1]);
                end
            end
            if (mac_clear) clr_cyc.push_back(c);
            if (done_0) begin order.push_back(0); done_cyc.push_back(c); end
            if (done_1) begin order.push_back(1); done_cyc.push_back(c); end
        end
        checks++;
        if (order.size() != 3 || order[0] != 0 || order[1] != 1 || order[2] != 0) begin
            errors++;
            $display("FAIL rr_order: got %0d bursts %p want 0,1,0", order.size(), order);
        end else begin
            checks++;
            if (clr_cyc.size() != 3 || clr_cyc[1] - done_cyc[0] != 2 || clr_cyc[2] - done_cyc[1] != 2) begin
                errors++;
                $display("FAIL rr_gap: got clears %p dones %p want next clear 2 cycles after done",
                         clr_cyc, done_cyc);
            end
        end
    endtask

    task automatic test_stall();
        // grant, beat, stall, stall, beat, last beat, idle, idle
        bit   r0v [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
        bit   l0v [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
        int   done_n = 0;
        drive_cycle(idle_stim(1'b1));
        for (int c = 0; c < 8; c++) begin
            stim_t s = idle_stim(1'b0);
            s.r0 = r0v[c]; s.l0 = l0v[c]; s.a0 = W'(c + 16); s.b0 = W'(c + 32);
            s.r1 = (c < 6);
            s.a1 = 8'hEE; s.b1 = 8'hDD;
            drive_cycle(s);
            checks++;
            if ({obs_ack, snap()} !== {exp_ack, exp_o}) begin
                errors++;
                $display("FAIL stall_model cyc %0d: got %b/%h want %b/%h", c, obs_ack, snap(), exp_ack, exp_o);
            end
            if (c == 2 || c == 3) begin
                checks++;
                if ({mac_en, busy, obs_ack} !== {1'b0, 1'b1, 2'b00}) begin
                    errors++;
                    $display("FAIL stall_hold cyc %0d: got en %b busy %b ack %b want 0 1 00",
                             c, mac_en, busy, obs_ack);
                end
            end
            if (done_0) begin
                done_n++;
                checks++;
                if (c != 5 || beat_count !== CW'(3)) begin
                    errors++;
                    $display("FAIL stall_done: got cyc %0d cnt %0d want cyc 5 cnt 3", c, beat_count);
                end
            end
        end
        checks++;
        if (done_n != 1) begin
            errors++;
            $display("FAIL stall_done_count: got %0d want 1", done_n);
        end
    endtask

    task automatic test_max_burst();
        int done_n = 0;
        drive_cycle(idle_stim(1'b1));
        for (int c = 0; c < 7; c++) begin
            stim_t s = idle_stim(1'b0);
            s.r0 = (done_n == 0); s.l0 = 0; s.a0 = W'($urandom); s.b0 = W'($urandom);
            drive_cycle(s);
            checks++;
            if ({obs_ack, snap()} !== {exp_ack, exp_o}) begin
                errors++;
                $display("FAIL max_model cyc %0d: got %b/%h want %b/%h", c, obs_ack, snap(), exp_ack, exp_o);
            end
            if (done_0) begin
                done_n++;
                checks++;
                if (c != 4 || {mac_last, beat_count, busy} !== {1'b1, CW'(MB), 1'b0}) begin
                    errors++;
                    $display("FAIL max_forced_last: got cyc %0d last %b cnt %0d busy %b want cyc 4 1 %0d 0",
                             c, mac_last, beat_count, busy, MB);
                end
            end
        end
        checks++;
        if (done_n != 1) begin
            errors++;
            $display("FAIL max_done_count: got %0d want 1", done_n);
        end
    endtask

    task automatic test_reset_mid_burst();
        stim_t s;
        drive_cycle(idle_stim(1'b1));
        for (int c = 0; c < 3; c++) begin
            s = idle_stim(1'b0);
            s.r1 = 1; s.a1 = W'(c + 1); s.b1 = W'(c + 9);
            drive_cycle(s);
        end
        checks++;
        if ({busy, select, beat_count} !== {1'b1, 1'b1, CW'(2)}) begin
            errors++;
            $display("FAIL midrst_pre: got busy %b sel %b cnt %0d want 1 1 2", busy, select, beat_count);
        end
        s = idle_stim(1'b1);
        s.r1 = 1; s.l1 = 1;
        drive_cycle(s);
        checks++;
        if ({obs_ack, snap()} !== {2'b00, out_t'('0)}) begin
            errors++;
            $display("FAIL midrst_outputs: got ack %b out %h want all zero", obs_ack, snap());
        end
        s = idle_stim(1'b0);
        s.r0 = 1; s.r1 = 1;
        drive_cycle(s);
        drive_cycle(s);
        checks++;
        if ({obs_ack, select, busy} !== {2'b01, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL midrst_regrant: got ack %b sel %b busy %b want 01 0 1", obs_ack, select, busy);
        end
    endtask

    task automatic test_random();
        drive_cycle(idle_stim(1'b1));
        for (int c = 0; c < 600; c++) begin
            stim_t s;
            s.rst = ($urandom_range(63) == 0);
            s.r0  = ($urandom_range(3) != 0);
            s.l0  = ($urandom_range(3) == 0);
            s.a0  = W'($urandom); s.b0 = W'($urandom);
            s.r1  = ($urandom_range(3) != 0);
            s.l1  = ($urandom_range(3) == 0);
            s.a1  = W'($urandom); s.b1 = W'($urandom);
            drive_cycle(s);
            checks++;
            if ({obs_ack, snap()} !== {exp_ack, exp_o}) begin
                errors++;
                $display("FAIL random_model cyc %0d: got %b/%h want %b/%h", c, obs_ack, snap(), exp_ack, exp_o);
            end
        end
    endtask

    initial begin
        reset = 1; req_0 = 0; last_0 = 0; a_0 = '0; b_0 = '0;
        req_1 = 0; last_1 = 0; a_1 = '0; b_1 = '0;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_count = 0; exp_o = '0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_stall();
        test_max_burst();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
